// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory (req/ack) plus the
// pipeline stall/flush generator that merges memory waits, branches and load-use.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadE,
  input  logic [4:0]  RdE,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic        PCSrcE,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_mem_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        w_acc;
  logic        w_timeout;
  logic        w_memstall;
  logic        w_lu;

  assign w_acc      = MemReadM | MemWriteM;
  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_memstall = ((r_state == S_IDLE) && w_acc) || (r_state == S_BUSY);
  assign w_lu       = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_mem_addr  <= ALUResultM;
            r_mem_wdata <= WriteDataM;
            r_mem_we    <= MemWriteM;
            r_mem_req   <= 1'b1;
            r_cnt       <= 8'd0;
          end
        end
        S_BUSY: begin
          // A completing ack takes precedence over a timeout in the same cycle.
          if (mem_ack) begin
            if (!r_mem_we) r_rdata <= mem_rdata;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            if (!r_mem_we) r_rdata <= 32'd0;
            r_mem_err <= 1'b1;
            r_mem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Priority: memory wait > taken branch > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ReadDataM = r_rdata;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a transaction-level driver pushes expected
// requests, completions and per-cycle hazard controls; a negedge monitor checks them.
module tb_mem_stage_ctrl;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        MemReadE = 1'b0;
  logic [4:0]  RdE = '0, Rs1D = '0, Rs2D = '0;
  logic        PCSrcE = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ReadDataM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D), .PCSrcE(PCSrcE),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct { int stalls; logic [31:0] rd; logic err; } cmp_t;

  req_t       req_q[$];
  cmp_t       cmp_q[$];
  logic [6:0] ctl_q[$];

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   force_hz = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} from the hazard rules.
  function automatic logic [6:0] exp_ctl(input bit memstall, input logic mre,
                                         input logic [4:0] rde, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic pcs);
    bit lu = mre && (rde != 0) && (rde == rs1 || rde == rs2);
    if (memstall) return 7'b1111_001;
    if (pcs)      return 7'b0000_110;
    if (lu)       return 7'b1100_010;
    return 7'b0;
  endfunction

  task automatic set_hazard();
    if (force_hz) begin
      MemReadE = 1'b1; RdE = 5'd5; Rs1D = 5'd0; Rs2D = 5'd5; PCSrcE = 1'b1;
    end else begin
      MemReadE = 1'($urandom_range(0, 1));
      RdE      = 5'($urandom_range(0, 3));
      Rs1D     = 5'($urandom_range(0, 3));
      Rs2D     = 5'($urandom_range(0, 3));
      PCSrcE   = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic step(input bit memstall);
    ctl_q.push_back(exp_ctl(memstall, MemReadE, RdE, Rs1D, Rs2D, PCSrcE));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    MemReadM = 1'b0; MemWriteM = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    set_hazard();
    step(1'b0);
    mem_ack = 1'b0;
  endtask

  task automatic hz_cycle(input logic mre, input logic [4:0] rde, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic pcs);
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
    MemReadE = mre; RdE = rde; Rs1D = rs1; Rs2D = rs2; PCSrcE = pcs;
    step(1'b0);
  endtask

  // n = BUSY cycle (1-based) carrying the ack; n > TO means the memory never answers.
  task automatic access(input bit st, input logic [31:0] a, input logic [31:0] d,
                        input int n, input logic [31:0] rdat);
    int busy = (n > TO) ? TO : n;
    MemReadM = !st; MemWriteM = st; ALUResultM = a; WriteDataM = d;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    set_hazard();
    req_q.push_back('{a, st, d});
    step(1'b1);
    for (int i = 1; i <= busy; i++) begin
      mem_ack = (i == n);
      mem_rdata = (i == n) ? rdat : $urandom;
      set_hazard();
      step(1'b1);
    end
    if (!st) m_rd = (n > TO) ? 32'd0 : rdat;
    if (n > TO) m_err = 1'b1;
    cmp_q.push_back('{busy + 1, m_rd, m_err});
    // DONE: instruction still presented and a stray ack, both must be ignored.
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    set_hazard();
    step(1'b0);
    mem_ack = 1'b0;
  endtask

  // Monitor
  initial begin
    logic       prev_req;
    int         run;
    logic [6:0] ec;
    req_t       er;
    cmp_t       ecmp;
    prev_req = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ctl_q.size() > 0) begin
          ec = ctl_q.pop_front();
          chk("ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, ec});
        end
        if (mem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got request addr 0x%08h expected none", mem_addr);
          end else begin
            er = req_q.pop_front();
            chk("mem_addr", mem_addr, er.addr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, er.we});
            chk("mem_wdata", mem_wdata, er.wdata);
          end
        end
        if (StallM) begin
          if (run > 0) chk("req_hold", {31'd0, mem_req}, 32'd1);
          run++;
        end else if (run > 0) begin
          if (cmp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got completion after %0d stalls expected none", run);
          end else begin
            ecmp = cmp_q.pop_front();
            chk("stall_cycles", run, ecmp.stalls);
            chk("ReadDataM", ReadDataM, ecmp.rd);
            chk("mem_err", {31'd0, mem_err}, {31'd0, ecmp.err});
            chk("req_drop", {31'd0, mem_req}, 32'd0);
          end
          run = 0;
        end
      end else begin
        run = 0;
      end
      prev_req = mem_req;
    end
  end

  // Driver
  initial begin
    // Reset state
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a BUSY wait
    MemReadM = 1'b1; ALUResultM = 32'h0000_0080;
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    chk("busy_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, mem_req}, 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_rdata", ReadDataM, 32'd0);
    chk("late_ack_ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'd0);
    @(posedge clk); #1;
    chk("late_ack_req2", {31'd0, mem_req}, 32'd0);

    mon_en = 1'b1;
    // Directed scenarios
    access(1'b0, 32'h0000_0040, $urandom, 1, 32'hDEAD_BEEF);
    idle_cycle();
    access(1'b1, 32'h0000_0100, 32'h1234_5678, 5, $urandom);
    hz_cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
    hz_cycle(1'b0, 5'd5, 5'd0, 5'd5, 1'b0);
    hz_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    hz_cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
    force_hz = 1'b1;
    access(1'b0, 32'h0000_0200, $urandom, 3, 32'h0BAD_F00D);
    force_hz = 1'b0;
    access(1'b0, 32'h0000_0300, $urandom, TO + 1, $urandom);
    idle_cycle();
    access(1'b1, 32'h0000_0304, 32'hCAFE_0001, TO + 1, $urandom);
    access(1'b0, 32'h0000_0308, $urandom, 2, 32'h5A5A_A5A5);
    access(1'b1, 32'h0000_030C, 32'h0F0F_0F0F, 1, $urandom);

    // Randomized mix including back-to-back accesses
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 2))
        0: idle_cycle();
        1: access(1'b0, $urandom, $urandom, $urandom_range(1, TO + 1), $urandom);
        default: access(1'b1, $urandom, $urandom, $urandom_range(1, TO + 1), $urandom);
      endcase
    end
    idle_cycle();
    idle_cycle();
    @(negedge clk); #1;
    chk("ctl_q_drained", ctl_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("cmp_q_drained", cmp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage of the 5-stage RISC-V pipeline against a variable-latency data memory using a req/ack handshake.
- Generates the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Combines memory-wait stalls with load-use and taken-branch hazards under one fixed priority.
- Sits beside the EX/MEM and MEM/WB registers. It drives ReadDataM into MEM/WB and a bubble request to the MEM/WB input.

Parameters:
- TIMEOUT, 255, maximum cycles in BUSY without mem_ack before abort; the counter is 8 bits wide and TIMEOUT ranges 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteM  in  1  MEM-stage instruction is a store.
- ALUResultM  in  32  MEM-stage byte address.
- WriteDataM  in  32  store data.
- MemReadE  in  1  EX-stage instruction is a load.
- RdE  in  5  EX destination register.
- Rs1D  in  5  ID source register 1.
- Rs2D  in  5  ID source register 2.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  load data, valid with mem_ack.
- ReadDataM  out  32  captured load data into MEM/WB.
- StallF, StallD, StallE, StallM  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
- FlushD, FlushE  out  1 each  clear IF/ID, ID/EX.
- FlushW  out  1  force bubble (RegWrite=0) into MEM/WB this edge.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, ReadDataM and mem_err all 0, immediately.
  - Combinational outputs follow from IDLE.
  - Reset mid-access drops mem_req without waiting for ack. An ack arriving after reset is ignored.
- FSM, three states:
  - IDLE: acc = MemReadM|MemWriteM. If acc, latch mem_addr<=ALUResultM, mem_wdata<=WriteDataM, mem_we<=MemWriteM, set mem_req<=1, counter<=0, go to BUSY.
  - BUSY: mem_req held at 1. On mem_ack, ReadDataM<=mem_rdata (loads only; stores leave it unchanged), mem_req<=0, go to DONE. Otherwise counter increments. If counter==TIMEOUT-1 with no ack, set mem_err<=1, ReadDataM<=0 (load), mem_req<=0, go to DONE.
  - DONE: all mem stalls released for one cycle so the instruction advances to WB. No new access detection in this state. Always go to IDLE.
- memstall = (IDLE & acc) | BUSY.
  - While memstall: StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0 while memstall, because EX is held and PCSrcE and the load-use condition re-evaluate afterwards.
- Load-use, only when memstall=0: lu = MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D). If lu, StallF=StallD=1 and FlushE=1.
- Branch, only when memstall=0: PCSrcE gives FlushD=1 and FlushE=1. If lu and PCSrcE coincide, branch wins: StallF=StallD=0, FlushD=FlushE=1.
- Priority: memory stall > branch flush > load-use.
- Latency:
  - Ack in the first BUSY cycle gives 2 stall cycles (IDLE detect + BUSY) and 1 DONE cycle.
  - Each extra wait cycle adds one stall cycle.
- Back-to-back accesses: after DONE→IDLE, the next MEM instruction is detected in IDLE and costs no additional idle cycle.
- mem_ack in IDLE or DONE is ignored. mem_req never falls before ack or timeout.
- mem_err clears only on reset. It does not block later accesses.

Test Plan:
- Reset pulse mid-BUSY (mem_req=1): rst low → mem_req=0 in the same cycle, all stalls 0 after release, state IDLE, late mem_ack ignored.
- Load at 0x0000_0040, mem_ack on the first BUSY cycle with rdata 0xDEAD_BEEF:
  - Stalls high for 2 cycles, FlushW high for 2 cycles.
  - mem_addr=0x40, mem_we=0.
  - ReadDataM=0xDEADBEEF in DONE, stalls low.
- Store 0x1234_5678 to 0x100, ack after 5 cycles: mem_we=1, mem_wdata=0x12345678, 6 stall cycles, ReadDataM unchanged.
- Load-use (MemReadE=1, RdE=5, Rs2D=5, no mem access): StallF=StallD=FlushE=1 for 1 cycle. With RdE=0, no stall.
- Load-use coincident with PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0. Repeat during a BUSY memory wait: only mem stalls asserted, flushes 0.
- TIMEOUT=4, no ack: mem_req held for 4 cycles then drops, mem_err=1 and stays set, ReadDataM=0, next access proceeds normally.
